// File: rtl/fas_frame_sched.sv
// rtl/fas_frame_sched.sv - FIR-to-FFT ping-pong frame scheduler with serial peak-bin search.
module fas_frame_sched #(
  parameter int NUM_FRAMES = 64,
  parameter int MAG_W      = 32,
  parameter int SKIP_DC    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fir_valid,
  output logic             buf_we,
  output logic [4:0]       buf_waddr,
  output logic             fft_start,
  output logic             fft_bank,
  input  logic             fft_valid,
  output logic [3:0]       bin_sel,
  input  logic [MAG_W-1:0] bin_mag,
  output logic [3:0]       freq,
  output logic             freq_valid,
  output logic             done,
  output logic             overrun
);

  localparam int FC_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [FC_W-1:0] LAST_FRAME = FC_W'(NUM_FRAMES - 1);

  typedef enum logic [2:0] {
    C_IDLE, C_START, C_WAIT, C_SCAN, C_REPORT, C_DONE
  } state_t;

  state_t state_q, state_d;

  logic             wr_bank_q, wr_bank_d;
  logic [3:0]       wr_idx_q, wr_idx_d;
  logic [1:0]       full_q, full_d;
  logic             rd_bank_q, rd_bank_d;
  logic [3:0]       bin_sel_q, bin_sel_d;
  logic [MAG_W-1:0] max_q, max_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       freq_q, freq_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  logic write_fire;
  logic fft_done;

  always_ff @(posedge clk) begin
    if (rst) state_q <= C_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      C_IDLE:   if (full_q[rd_bank_q]) state_d = C_START;
      C_START:  state_d = C_WAIT;
      C_WAIT:   if (fft_valid) state_d = C_SCAN;
      C_SCAN:   if (bin_sel_q == 4'd15) state_d = C_REPORT;
      C_REPORT: state_d = (frame_cnt_q == LAST_FRAME) ? C_DONE : C_IDLE;
      C_DONE:   state_d = C_DONE;
      default:  state_d = C_IDLE;
    endcase
  end

  always_comb begin
    fft_start  = (state_q == C_START);
    freq_valid = (state_q == C_REPORT);
    fft_bank   = rd_bank_q;
    bin_sel    = bin_sel_q;
    // Show the new peak in the same cycle as the pulse; hold it afterwards.
    freq       = freq_valid ? idx_q : freq_q;
    done       = done_q;
    overrun    = overrun_q;
    buf_we     = write_fire;
    buf_waddr  = {wr_bank_q, wr_idx_q};
  end

  assign write_fire = fir_valid && !full_q[wr_bank_q] && !done_q;
  assign fft_done   = (state_q == C_WAIT) && fft_valid;

  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    full_d      = full_q;
    rd_bank_d   = rd_bank_q;
    bin_sel_d   = bin_sel_q;
    max_d       = max_q;
    idx_d       = idx_q;
    freq_d      = freq_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = done_q;
    overrun_d   = overrun_q | (fir_valid && full_q[wr_bank_q] && !done_q);

    if (write_fire) begin
      wr_idx_d = wr_idx_q + 4'd1;
      if (wr_idx_q == 4'd15) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    // The bank being cleared is full, so it can never be the one being set here.
    if (fft_done) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      bin_sel_d         = 4'd0;
    end

    if (state_q == C_SCAN) begin
      bin_sel_d = bin_sel_q + 4'd1;
      if (bin_sel_q == 4'd0) begin
        if (SKIP_DC != 0) begin
          max_d = '0;
          idx_d = 4'd1;
        end else begin
          max_d = bin_mag;
          idx_d = 4'd0;
        end
      end else if (bin_mag > max_q) begin
        max_d = bin_mag;
        idx_d = bin_sel_q;
      end
    end

    if (state_q == C_REPORT) begin
      freq_d      = idx_q;
      frame_cnt_d = frame_cnt_q + FC_W'(1);
      if (frame_cnt_q == LAST_FRAME) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= 4'd0;
      full_q      <= 2'b00;
      rd_bank_q   <= 1'b0;
      bin_sel_q   <= 4'd0;
      max_q       <= '0;
      idx_q       <= 4'd0;
      freq_q      <= 4'd0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      full_q      <= full_d;
      rd_bank_q   <= rd_bank_d;
      bin_sel_q   <= bin_sel_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      freq_q      <= freq_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_fas_frame_sched.sv
// tb/tb_fas_frame_sched.sv - directed vector bench for fas_frame_sched (NUM_FRAMES=4 and a SKIP_DC twin).
module tb_fas_frame_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, fir_valid, fft_valid;
  logic [31:0] mags [16];

  logic        a_we, a_start, a_bank, a_fv, a_done, a_ovr;
  logic [4:0]  a_waddr;
  logic [3:0]  a_binsel, a_freq;
  logic [31:0] a_mag;
  logic        b_we, b_start, b_bank, b_fv, b_done, b_ovr;
  logic [4:0]  b_waddr;
  logic [3:0]  b_binsel, b_freq;
  logic [31:0] b_mag;

  assign a_mag = mags[a_binsel];
  assign b_mag = mags[b_binsel];

  fas_frame_sched #(.NUM_FRAMES(4), .MAG_W(32), .SKIP_DC(0)) dut_a (
    .clk(clk), .rst(rst), .fir_valid(fir_valid), .buf_we(a_we), .buf_waddr(a_waddr),
    .fft_start(a_start), .fft_bank(a_bank), .fft_valid(fft_valid), .bin_sel(a_binsel),
    .bin_mag(a_mag), .freq(a_freq), .freq_valid(a_fv), .done(a_done), .overrun(a_ovr)
  );

  fas_frame_sched #(.NUM_FRAMES(64), .MAG_W(32), .SKIP_DC(1)) dut_b (
    .clk(clk), .rst(rst), .fir_valid(fir_valid), .buf_we(b_we), .buf_waddr(b_waddr),
    .fft_start(b_start), .fft_bank(b_bank), .fft_valid(fft_valid), .bin_sel(b_binsel),
    .bin_mag(b_mag), .freq(b_freq), .freq_valid(b_fv), .done(b_done), .overrun(b_ovr)
  );

  int n_cmp = 0;
  int n_err = 0;
  int a_pulses = 0;

  always @(posedge clk) begin
    if (rst) a_pulses <= 0;
    else if (a_fv) a_pulses <= a_pulses + 1;
  end

  typedef struct {
    logic       fir;
    logic       exp_we;
    logic [4:0] exp_waddr;
    logic       exp_start;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic f, input logic v);
    fir_valid = f;
    fft_valid = v;
    #1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mags(input logic [31:0] fill);
    for (int i = 0; i < 16; i++) mags[i] = fill;
  endtask

  // Wait (bounded) for a_fv; expect it exactly 17 cycles after the fft_valid cycle.
  task automatic await_report(input logic [3:0] exp_a, input logic [3:0] exp_b);
    int k;
    k = 0;
    for (int j = 1; j <= 20; j++) begin
      drive(1'b0, 1'b0);
      if (a_fv) begin
        k = j;
        break;
      end
      nxt();
    end
    chk("fv_latency", 32'(k), 32'd17);
    chk("freq_a", 32'(a_freq), 32'(exp_a));
    chk("freq_b", 32'(b_freq), 32'(exp_b));
    chk("fv_b", 32'(b_fv), 32'd1);
  endtask

  task automatic run_frame(input int base, input logic [3:0] exp_a, input logic [3:0] exp_b);
    int lat;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0);
      chk("frm_we", 32'(a_we), 32'd1);
      chk("frm_waddr", 32'(a_waddr), 32'(base + i));
      nxt();
    end
    lat = -1;
    for (int j = 0; j < 5; j++) begin
      drive(1'b0, 1'b0);
      if (a_start) begin
        lat = j;
        break;
      end
      nxt();
    end
    chk("start_latency", 32'(lat), 32'd1);
    chk("start_bank", 32'(a_bank), 32'(base / 16));
    nxt();
    drive(1'b0, 1'b1);
    nxt();
    await_report(exp_a, exp_b);
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 19; i++) begin
      vecs[i].fir       = (i < 16);
      vecs[i].exp_we    = (i < 16);
      vecs[i].exp_waddr = (i < 16) ? 5'(i) : 5'd16;
      vecs[i].exp_start = (i == 17);
    end

    rst = 1'b1;
    fir_valid = 1'b0;
    fft_valid = 1'b0;
    set_mags(32'd100);
    mags[9] = 32'd5000;
    nxt();
    nxt();
    drive(1'b0, 1'b0);
    chk("rst_we", 32'(a_we), 32'd0);
    chk("rst_waddr", 32'(a_waddr), 32'd0);
    chk("rst_start", 32'(a_start), 32'd0);
    chk("rst_freq", 32'(a_freq), 32'd0);
    chk("rst_fv", 32'(a_fv), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_ovr", 32'(a_ovr), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].fir, 1'b0);
      chk("vec_we", 32'(a_we), 32'(vecs[i].exp_we));
      chk("vec_waddr", 32'(a_waddr), 32'(vecs[i].exp_waddr));
      chk("vec_start", 32'(a_start), 32'(vecs[i].exp_start));
      chk("vec_bank", 32'(a_bank), 32'd0);
      chk("vec_fv", 32'(a_fv), 32'd0);
      nxt();
    end

    // Frame 1: fft_valid five cycles after fft_start, peak at bin 9.
    repeat (3) begin
      drive(1'b0, 1'b0);
      chk("wait_start", 32'(a_start), 32'd0);
      nxt();
    end
    drive(1'b0, 1'b1);
    chk("wait_bank", 32'(a_bank), 32'd0);
    nxt();
    for (int k = 1; k <= 16; k++) begin
      drive(1'b0, 1'b0);
      chk("scan_binsel", 32'(a_binsel), 32'(k - 1));
      chk("scan_fv", 32'(a_fv), 32'd0);
      nxt();
    end
    drive(1'b0, 1'b0);
    chk("f1_fv", 32'(a_fv), 32'd1);
    chk("f1_freq", 32'(a_freq), 32'd9);
    chk("f1_freq_b", 32'(b_freq), 32'd9);
    nxt();
    drive(1'b0, 1'b0);
    chk("f1_pulse_end", 32'(a_fv), 32'd0);
    chk("f1_freq_hold", 32'(a_freq), 32'd9);

    // Frame 2: tie at bins 3 and 11 keeps the lower index.
    set_mags(32'd7);
    mags[3]  = 32'hFFFF_FFFF;
    mags[11] = 32'hFFFF_FFFF;
    run_frame(16, 4'd3, 4'd3);

    // Frame 3: DC dominates; the SKIP_DC twin reports the largest non-DC bin.
    set_mags(32'd50);
    mags[0] = 32'hFFFF_FFFF;
    mags[6] = 32'd900;
    run_frame(0, 4'd0, 4'd6);
    drive(1'b0, 1'b0);
    chk("pre_done", 32'(a_done), 32'd0);
    chk("pulses_3", 32'(a_pulses), 32'd3);

    // 48-sample burst with the FFT stalled: banks 1 then 0 fill, the rest drop.
    set_mags(32'd100);
    mags[15] = 32'd1000;
    for (int i = 0; i < 48; i++) begin
      drive(1'b1, 1'b0);
      chk("ovr_we", 32'(a_we), 32'(i < 32));
      chk("ovr_waddr", 32'(a_waddr), (i < 16) ? 32'(16 + i) : (i < 32) ? 32'(i - 16) : 32'd16);
      chk("ovr_flag", 32'(a_ovr), 32'(i >= 33));
      chk("ovr_start", 32'(a_start), 32'(i == 17));
      nxt();
    end
    drive(1'b0, 1'b0);
    chk("ovr_sticky", 32'(a_ovr), 32'd1);
    drive(1'b0, 1'b1);
    nxt();
    await_report(4'd15, 4'd15);
    chk("done_not_yet", 32'(a_done), 32'd0);
    nxt();
    drive(1'b0, 1'b0);
    chk("done_set", 32'(a_done), 32'd1);
    chk("pulses_4", 32'(a_pulses), 32'd4);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0);
      chk("post_done_we", 32'(a_we), 32'd0);
      chk("post_done_start", 32'(a_start), 32'd0);
      nxt();
    end
    drive(1'b0, 1'b0);
    chk("post_done_pulses", 32'(a_pulses), 32'd4);
    chk("post_done_ovr", 32'(a_ovr), 32'd1);
    chk("post_done_hold", 32'(a_done), 32'd1);

    // Reset taken in the middle of a scan.
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0);
      nxt();
    end
    repeat (2) begin
      drive(1'b0, 1'b0);
      nxt();
    end
    drive(1'b0, 1'b1);
    nxt();
    repeat (5) begin
      drive(1'b0, 1'b0);
      nxt();
    end
    drive(1'b0, 1'b0);
    chk("mid_scan_binsel", 32'(a_binsel), 32'd5);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    drive(1'b0, 1'b0);
    chk("mr_we", 32'(a_we), 32'd0);
    chk("mr_waddr", 32'(a_waddr), 32'd0);
    chk("mr_start", 32'(a_start), 32'd0);
    chk("mr_bank", 32'(a_bank), 32'd0);
    chk("mr_binsel", 32'(a_binsel), 32'd0);
    chk("mr_freq", 32'(a_freq), 32'd0);
    chk("mr_fv", 32'(a_fv), 32'd0);
    chk("mr_done", 32'(a_done), 32'd0);
    chk("mr_ovr", 32'(a_ovr), 32'd0);
    chk("mr_binsel_b", 32'(b_binsel), 32'd0);
    set_mags(32'd10);
    mags[4] = 32'd20;
    run_frame(0, 4'd4, 4'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fas_frame_sched.md
Name: fas_frame_sched

Overview:
- Frame scheduler for the FAS datapath. It sits between the FIR output stream and the 16-point FFT / spectrum-analysis stage.
- Packs FIR samples into a ping-pong 2x16 frame buffer, launches the FFT on each full bank, and serially scans the 16 bin magnitudes for the peak.
- Reports freq per frame; raises done after NUM_FRAMES frames.

Parameters:
- NUM_FRAMES, 64, frames to process before done (1024 samples / 16).
- MAG_W, 32, width of the bin magnitude input.
- SKIP_DC, 0, when 1, bin 0 is excluded from the peak search.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- fir_valid  in  1  FIR sample strobe, one sample per asserted cycle.
- buf_we  out  1  frame-buffer write enable (combinational, same cycle as fir_valid).
- buf_waddr  out  5  {bank, index} write address.
- fft_start  out  1  one-cycle FFT launch pulse.
- fft_bank  out  1  bank the FFT reads; stable from fft_start until fft_valid.
- fft_valid  in  1  FFT result ready; FFT has consumed its bank.
- bin_sel  out  4  bin index presented to the magnitude unit.
- bin_mag  in  MAG_W  unsigned magnitude of bin bin_sel (combinational from bin_sel).
- freq  out  4  peak bin of the last reported frame.
- freq_valid  out  1  one-cycle pulse, freq updated.
- done  out  1  sticky, all frames reported.
- overrun  out  1  sticky, a sample was dropped.

Behaviour:
Reset:
- Clears all outputs, counters, both full flags, wr_bank = rd_bank = 0, and the compute FSM to C_IDLE.
- Reset mid-frame discards buffer contents; no partial-frame state survives.

Write side (independent of compute FSM):
- fir_valid && !full[wr_bank] && !done: buf_we = 1 and buf_waddr = {wr_bank, wr_idx}; wr_idx increments.
- On the write with wr_idx == 15: set full[wr_bank], toggle wr_bank, wr_idx wraps to 0.
- fir_valid && full[wr_bank]: sample dropped, buf_we = 0, overrun <= 1.
- fir_valid after done: ignored; does not set overrun.

Compute FSM states: C_IDLE, C_START, C_WAIT, C_SCAN, C_REPORT, C_DONE.
- C_IDLE: if full[rd_bank], go to C_START.
- C_START: fft_start = 1, fft_bank = rd_bank; go to C_WAIT.
- C_WAIT: hold until fft_valid. On fft_valid: clear full[rd_bank], toggle rd_bank, bin_sel <= 0, go to C_SCAN.
- C_WAIT: fft_valid seen in any other state is ignored.
- Full-flag collisions: clearing full[rd_bank] and setting full of the other bank in the same cycle are both honoured. The write side can never set a bank that is being cleared, because that bank is full.
- C_SCAN: one bin per cycle, bin_sel 0..15.
  - At bin 0: max <= bin_mag, idx <= 0. When SKIP_DC = 1: max <= 0, idx <= 1.
  - Other bins: update max and idx only if bin_mag > max (strict compare; ties keep the lower index).
  - After bin 15, go to C_REPORT.
- C_REPORT: freq <= idx, freq_valid = 1 for one cycle, frame_cnt++.
  - If frame_cnt == NUM_FRAMES-1: done <= 1 and go to C_DONE; otherwise go to C_IDLE.
- C_DONE: terminal until rst. fft_start is never asserted again.

Latency:
- fft_valid at cycle T: bins scanned T+1..T+16, freq_valid at T+17.
- Full bank to fft_start: 2 cycles (C_IDLE, then C_START).

Arithmetic:
- Unsigned MAG_W compare. frame_cnt is ceil(log2(NUM_FRAMES)) bits.

Test Plan:
- Continuous fir_valid for 16 cycles: buf_waddr 0..15, full[0] set, and fft_start pulses with fft_bank = 0 two cycles after the 16th write.
- fft_valid after 5 cycles with bin_mag = 100 except bin 9 = 5000: freq_valid exactly 17 cycles after fft_valid, freq = 9.
- Tie case: bins 3 and 11 both = 0xFFFF_FFFF: freq = 3. With SKIP_DC = 1 and bin 0 largest: freq is the largest non-zero bin.
- fir_valid continuous for 48 cycles with fft_valid withheld: banks 0 and 1 fill, samples 33..48 dropped (buf_we = 0), overrun = 1 and stays set.
- NUM_FRAMES = 4, full stream: exactly four freq_valid pulses, then done = 1; further fir_valid produces no buf_we and no fft_start.
- rst asserted during C_SCAN: next cycle all outputs 0 and the state is C_IDLE; a new 16-sample stream restarts at buf_waddr 0.
